exp_inv_search: RTL and testbench
=================================

// Module: exp_inv_search
// PURPOSE
//  Inverse of the 2*exp(-x)*pixel shift-add weighting used in the recognition datapath.
//  Given a pixel value and a weighted value, finds the smallest integer x in 0..10 whose
//  shift-add weight w(x) satisfies w(x) <= weight_data.
//  Sequential search, one candidate x per clock, valid/ready handshake on both sides.
//  Sits after the weighting stage to recover the distance index for feature scoring.
// PARAMETERS
//  DATA_W  10  pixel/weight width; the coefficient table is defined for 10 only
//  X_W     4   width of x_out; covers 0..10
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       request valid
//  in_ready     out  1       block can accept a request (high only in IDLE)
//  image_data   in   DATA_W  pixel multiplicand
//  weight_data  in   DATA_W  target weighted value
//  out_valid    out  1       result valid; held until out_ready
//  out_ready    in   1       downstream accepts result
//  x_out        out  X_W     smallest x with w(x) <= weight_data
//  w_out        out  DATA_W  w(x_out), bit-exact
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, x_out=0, w_out=0, x_cnt=0.
//  - w(x): shift-add of image_data with the fixed 15-bit fractional coefficients
//    x=0:<<1; x=1:>>1,3,4,5,6,10,12,13,14; x=2:>>2,6,8,10,14,15; x=3:>>4,5,8,10..15;
//    x=4:>>5,9,12,13,15; x=5:>>7,8,10,11,12,14; x=6:>>8,10,14,15; x=7:>>10,11,12,14;
//    x=8:>>11,14,15; x=9:>>13,14; x=10:>>14,15. Every term is truncated before summing;
//    the sum is truncated to DATA_W bits (x=0 wraps, e.g. 600 -> 176). Bit-exact.
//  - FSM: IDLE -> SEARCH on in_valid&&in_ready (latch both inputs, x_cnt=0).
//    SEARCH: each cycle evaluate w(x_cnt); record the first x with w<=weight_data.
//    SEARCH -> DONE per CONFIGURATION; DONE -> IDLE on out_ready (out_valid dropped).
//  - Comparison is unsigned. If no x matches, result is x=10 with w_out=w(10).
//    For DATA_W=10, w(9)=w(10)=0, so a match always exists.
//  - in_valid outside IDLE is ignored. It is not queued.
//  - out_valid&&out_ready and a new in_valid in the same cycle: the new request is
//    accepted on the following cycle, when the block is back in IDLE.
//  - rst mid-search or in DONE aborts the operation immediately and discards the result.
// CONFIGURATION
//  EXP_INV_EARLY_EXIT_EN defined: SEARCH ends at the first match.
//    Accept at cycle T, match at x=k -> out_valid at T+2+k.
//  Undefined: all 11 candidates are always scanned and the first match is kept.
//    Fixed latency: accept at T -> out_valid at T+12.
//  x_out and w_out are identical in both modes.
// STRUCTURE
//  - Package exp_weight_pkg: EXP_X_MAX=10, EXP_FRAC_W=15, the coefficient bitmask table
//    logic [14:0] EXP_COEF[0:10] (x=0 handled as <<1), and the FSM state typedef.
//  - Sub-module exp_weight_shift_add: combinational (image_data, x) -> w(x), reused by
//    the weighting stage.
//  - This module contains only the FSM, x_cnt, the input latches and the result registers.
// TESTING
//  1 image=100, weight=30 -> x_out=2, w_out=26; out_valid at T+4 (early) / T+12 (fixed).
//  2 image=100, weight=200 -> x_out=0, w_out=200; image=100, weight=0 -> x_out=5, w_out=0.
//  3 image=600, weight=180 -> x_out=0, w_out=176 (x=0 wrap); image=0 -> x_out=0, w_out=0.
//  4 out_ready held low 5 cycles: out_valid, x_out and w_out stay stable and in_ready=0;
//    a second in_valid during this time is not accepted.
//  5 rst pulsed in SEARCH: next cycle IDLE, out_valid=0, in_ready=1; a fresh request
//    then completes correctly.
//  6 Sweep image 0..1023 x random weight against a reference model: x_out and w_out
//    match exactly, and latency matches the compiled mode.

Source files
------------

// File: rtl/exp_weight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exp_weight_pkg
//  Description : Shared constants for the 2*exp(-x) shift-add weighting and
//                its inverse search: x range, fractional width, per-x
//                coefficient bitmasks and the search FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package exp_weight_pkg;

    localparam int EXP_X_MAX  = 10;
    localparam int EXP_FRAC_W = 15;

    // Bit i set means the term (pixel >> (i+1)) contributes to w(x).
    // x=0 is a plain left shift by one and is handled outside the table.
    localparam logic [EXP_FRAC_W-1:0] EXP_COEF [0:EXP_X_MAX] = '{
        15'h0000,   // x=0  : <<1 (special case)
        15'h3A3D,   // x=1  : >>1,3,4,5,6,10,12,13,14
        15'h62A2,   // x=2  : >>2,6,8,10,14,15
        15'h7E98,   // x=3  : >>4,5,8,10..15
        15'h5910,   // x=4  : >>5,9,12,13,15
        15'h2EC0,   // x=5  : >>7,8,10,11,12,14
        15'h6280,   // x=6  : >>8,10,14,15
        15'h2E00,   // x=7  : >>10,11,12,14
        15'h6400,   // x=8  : >>11,14,15
        15'h3000,   // x=9  : >>13,14
        15'h6000    // x=10 : >>14,15
    };

    typedef logic [1:0] exp_state_t;
    localparam exp_state_t ST_IDLE   = 2'd0;
    localparam exp_state_t ST_SEARCH = 2'd1;
    localparam exp_state_t ST_DONE   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/exp_weight_shift_add.sv
`default_nettype none
// ============================================================================
//  Module      : exp_weight_shift_add
//  Description : Combinational w(x) = 2*exp(-x)*pixel via truncated
//                shift-add terms; result truncated to DATA_W bits.
//  Revision    : 1.0  initial release
// ============================================================================
module exp_weight_shift_add
    import exp_weight_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int X_W    = 4
) (
    input  logic [DATA_W-1:0] image_data,
    input  logic [X_W-1:0]    x,
    output logic [DATA_W-1:0] w
);

    logic [EXP_FRAC_W-1:0] w_coef;
    logic [DATA_W:0]       w_acc;

    // Sum every selected term, each truncated by its own shift before adding.
    always_comb begin
        w_coef = (x <= X_W'(EXP_X_MAX)) ? EXP_COEF[x] : '0;
        w_acc  = '0;
        if (x == '0) begin
            w_acc = {image_data, 1'b0};
        end else begin
            for (int i = 0; i < EXP_FRAC_W; i++) begin
                if (w_coef[i]) begin
                    w_acc = w_acc + {1'b0, (image_data >> (i + 1))};
                end
            end
        end
        w = w_acc[DATA_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/exp_inv_search.sv
`default_nettype none
// ============================================================================
//  Module      : exp_inv_search
//  Description : Sequential inverse of the exp weighting: finds the smallest
//                x in 0..10 with w(x) <= weight_data, one candidate per clock.
//                Compile option EXP_INV_EARLY_EXIT_EN: stop at first match;
//                otherwise all 11 candidates are scanned (fixed latency).
//  Revision    : 1.0  initial release
// ============================================================================
module exp_inv_search
    import exp_weight_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int X_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] image_data,
    input  logic [DATA_W-1:0] weight_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [X_W-1:0]    x_out,
    output logic [DATA_W-1:0] w_out
);

    exp_state_t        r_state;
    exp_state_t        w_next_state;
    logic [X_W-1:0]    r_x_cnt;
    logic [DATA_W-1:0] r_image;
    logic [DATA_W-1:0] r_weight;
    logic [X_W-1:0]    r_x_res;
    logic [DATA_W-1:0] r_w_res;
    logic              r_found;
    logic [DATA_W-1:0] w_cand_w;
    logic              w_match;
    logic              w_last;
    logic              w_take;
    logic              w_accept;

    exp_weight_shift_add #(
        .DATA_W (DATA_W),
        .X_W    (X_W)
    ) u_weight (
        .image_data (r_image),
        .x          (r_x_cnt),
        .w          (w_cand_w)
    );

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_match  = (w_cand_w <= r_weight);
    assign w_last   = (r_x_cnt == X_W'(EXP_X_MAX));
    // Last candidate is taken unconditionally so a result always exists.
    assign w_take   = !r_found && (w_match || w_last);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
`ifdef EXP_INV_EARLY_EXIT_EN
                if (w_take || w_last) begin
                    w_next_state = ST_DONE;
                end
`else
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Input latches, candidate counter and first-match result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt  <= '0;
            r_image  <= '0;
            r_weight <= '0;
            r_x_res  <= '0;
            r_w_res  <= '0;
            r_found  <= 1'b0;
        end else if (w_accept) begin
            r_x_cnt  <= '0;
            r_image  <= image_data;
            r_weight <= weight_data;
            r_found  <= 1'b0;
        end else if (r_state == ST_SEARCH) begin
            if (w_take) begin
                r_x_res <= r_x_cnt;
                r_w_res <= w_cand_w;
                r_found <= 1'b1;
            end
            if (!w_last) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
        end
    end

    assign x_out = r_x_res;
    assign w_out = r_w_res;

endmodule
`default_nettype wire

// File: tb/tb_exp_inv_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_inv_search
//  Description : Directed and swept self-checking bench for exp_inv_search.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exp_inv_search;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] image_data;
    logic [9:0] weight_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] x_out;
    logic [9:0] w_out;

    int n_checks;
    int n_errors;

    exp_inv_search #(
        .DATA_W (10),
        .X_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .image_data  (image_data),
        .weight_data (weight_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .x_out       (x_out),
        .w_out       (w_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference weight written directly from the shift lists.
    function automatic int ref_w(input int img, input int x);
        int s;
        case (x)
            0:  s = img * 2;
            1:  s = (img>>1)+(img>>3)+(img>>4)+(img>>5)+(img>>6)+(img>>10)+(img>>12)+(img>>13)+(img>>14);
            2:  s = (img>>2)+(img>>6)+(img>>8)+(img>>10)+(img>>14)+(img>>15);
            3:  s = (img>>4)+(img>>5)+(img>>8)+(img>>10)+(img>>11)+(img>>12)+(img>>13)+(img>>14)+(img>>15);
            4:  s = (img>>5)+(img>>9)+(img>>12)+(img>>13)+(img>>15);
            5:  s = (img>>7)+(img>>8)+(img>>10)+(img>>11)+(img>>12)+(img>>14);
            6:  s = (img>>8)+(img>>10)+(img>>14)+(img>>15);
            7:  s = (img>>10)+(img>>11)+(img>>12)+(img>>14);
            8:  s = (img>>11)+(img>>14)+(img>>15);
            9:  s = (img>>13)+(img>>14);
            10: s = (img>>14)+(img>>15);
            default: s = 0;
        endcase
        return s & 1023;
    endfunction

    function automatic int exp_latency(input int x);
`ifdef EXP_INV_EARLY_EXIT_EN
        return 2 + x;
`else
        return 12;
`endif
    endfunction

    // Issue one request; lat = cycle offset of out_valid (T+lat), -1 on timeout.
    task automatic run_req(input logic [9:0] img, input logic [9:0] wt, input bit release_out,
                           output int x, output int w, output int lat);
        @(negedge clk);
        in_valid    = 1'b1;
        image_data  = img;
        weight_data = wt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        x = int'(x_out);
        w = int'(w_out);
        if (release_out && lat > 0) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (x_out !== 4'd0)     begin n_errors++; $display("FAIL reset_x_out got %0d want 0", x_out); end
        n_checks++; if (w_out !== 10'd0)    begin n_errors++; $display("FAIL reset_w_out got %0d want 0", w_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int img_t [6] = '{100, 100, 100, 600, 0, 0};
        int wt_t  [6] = '{30, 200, 0, 180, 0, 500};
        int ex_x  [6] = '{2, 0, 5, 0, 0, 0};
        int ex_w  [6] = '{26, 200, 0, 176, 0, 0};
        int x, w, lat;
        for (int i = 0; i < 6; i++) begin
            run_req(img_t[i][9:0], wt_t[i][9:0], 1'b1, x, w, lat);
            n_checks++; if (x !== ex_x[i]) begin n_errors++; $display("FAIL directed%0d_x got %0d want %0d", i, x, ex_x[i]); end
            n_checks++; if (w !== ex_w[i]) begin n_errors++; $display("FAIL directed%0d_w got %0d want %0d", i, w, ex_w[i]); end
            n_checks++; if (lat !== exp_latency(ex_x[i])) begin n_errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, exp_latency(ex_x[i])); end
        end
    endtask

    task automatic test_backpressure();
        int x, w, lat;
        run_req(10'd100, 10'd30, 1'b0, x, w, lat);
        n_checks++; if (lat !== exp_latency(2)) begin n_errors++; $display("FAIL bp_latency got %0d want %0d", lat, exp_latency(2)); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            image_data  = 10'd600;
            weight_data = 10'd0;
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid c%0d got %b want 1", c, out_valid); end
            n_checks++; if (x_out !== 4'd2)     begin n_errors++; $display("FAIL bp_hold_x c%0d got %0d want 2", c, x_out); end
            n_checks++; if (w_out !== 10'd26)   begin n_errors++; $display("FAIL bp_hold_w c%0d got %0d want 26", c, w_out); end
            n_checks++; if (in_ready !== 1'b0)  begin n_errors++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        // The requests offered while busy must not have been queued.
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL bp_not_queued got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_search();
        int x, w, lat;
        @(negedge clk);
        in_valid    = 1'b1;
        image_data  = 10'd100;
        weight_data = 10'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        n_checks++; if (x_out !== 4'd0)     begin n_errors++; $display("FAIL midrst_x got %0d want 0", x_out); end
        @(negedge clk);
        rst = 1'b0;
        run_req(10'd100, 10'd30, 1'b1, x, w, lat);
        n_checks++; if (x !== 2 || w !== 26) begin n_errors++; $display("FAIL midrst_fresh got x=%0d w=%0d want x=2 w=26", x, w); end
        n_checks++; if (lat !== exp_latency(2)) begin n_errors++; $display("FAIL midrst_latency got %0d want %0d", lat, exp_latency(2)); end
    endtask

    task automatic test_sweep();
        int x, w, lat, ex_x, ex_w, wt;
        for (int img = 0; img < 1024; img++) begin
            if ($urandom_range(0, 1) == 0) wt = int'($urandom_range(0, 1023));
            else                           wt = ref_w(img, int'($urandom_range(0, 10)));
            ex_x = 10;
            ex_w = ref_w(img, 10);
            for (int k = 0; k <= 10; k++) begin
                if (ref_w(img, k) <= wt) begin
                    ex_x = k;
                    ex_w = ref_w(img, k);
                    break;
                end
            end
            run_req(img[9:0], wt[9:0], 1'b1, x, w, lat);
            n_checks++;
            if (x !== ex_x || w !== ex_w || lat !== exp_latency(ex_x)) begin
                n_errors++;
                $display("FAIL sweep img=%0d wt=%0d got x=%0d w=%0d lat=%0d want x=%0d w=%0d lat=%0d",
                         img, wt, x, w, lat, ex_x, ex_w, exp_latency(ex_x));
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        image_data  = '0;
        weight_data = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_search();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
